// File: rtl/ldvio_pkg.sv
// Shared types and default sizing for the load-violation valid-bit write scheduler.
package ldvio_pkg;

    localparam int LDVIO_DEPTH      = 16;  // valid-RAM entries
    localparam int LDVIO_INDEX      = 4;   // log2(LDVIO_DEPTH)
    localparam int LDVIO_SETQ_DEPTH = 4;   // pending-set queue entries

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } ldvio_state_e;

    // One RAM write-port beat.
    typedef struct packed {
        logic                   we;
        logic [LDVIO_INDEX-1:0] addr;
        logic                   data;
    } ldvio_wr_t;

    // Pending-set queue slot; vld drops when a clear to the same entry kills it.
    typedef struct packed {
        logic                   vld;
        logic [LDVIO_INDEX-1:0] addr;
    } setq_ent_t;

endpackage

// File: rtl/ldvio_vld_ctrl_if.sv
// Request/RAM-write bundle of the valid-bit write scheduler.
// slave: the scheduler side; master: the requester/RAM side.
interface ldvio_vld_ctrl_if #(
    parameter int INDEX = 4
);
    logic             set_valid_i;
    logic [INDEX-1:0] set_addr_i;
    logic             set_ready_o;
    logic             clr_valid_i;
    logic [INDEX-1:0] clr_addr_i;
    logic             clr_ready_o;
    logic             flush_i;
    logic             busy_o;
    logic             we_o;
    logic [INDEX-1:0] waddr_o;
    logic             wdata_o;

    modport slave (
        input  set_valid_i, set_addr_i, clr_valid_i, clr_addr_i, flush_i,
        output set_ready_o, clr_ready_o, busy_o, we_o, waddr_o, wdata_o
    );

    modport master (
        output set_valid_i, set_addr_i, clr_valid_i, clr_addr_i, flush_i,
        input  set_ready_o, clr_ready_o, busy_o, we_o, waddr_o, wdata_o
    );
endinterface

// File: rtl/ldvio_setq.sv
// Circular FIFO of pending valid-bit sets with kill-by-address.
// A kill marks every matching slot dead; dead slots at the head are dropped in
// the same cycle, so head_live_o/head_addr_o always name the oldest live set.
// LDVIO_VLD_CTRL_PERF_EN adds the occupancy output cnt_o.
module ldvio_setq
    import ldvio_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [LDVIO_INDEX-1:0] push_addr_i,
    input  logic                   kill_i,
    input  logic [LDVIO_INDEX-1:0] kill_addr_i,
    input  logic                   pop_i,
    output logic                   head_live_o,
    output logic [LDVIO_INDEX-1:0] head_addr_o,
    output logic                   full_o,
    output logic                   empty_o
`ifdef LDVIO_VLD_CTRL_PERF_EN
    ,
    output logic [CW-1:0]          cnt_o
`endif
);

    setq_ent_t [DEPTH-1:0] ent_q, ent_d;
    logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         lead, npop;
    logic [PW-1:0]         idx;
    logic                  found;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
`ifdef LDVIO_VLD_CTRL_PERF_EN
    assign cnt_o   = cnt_q;
`endif

    // Kill, find oldest live entry, retire leading dead slots (+ head on pop), push.
    always_comb begin
        ent_d       = ent_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        lead        = '0;
        npop        = '0;
        idx         = '0;
        found       = 1'b0;
        head_addr_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_i && ent_q[i].vld && ent_q[i].addr == kill_addr_i)
                ent_d[i].vld = 1'b0;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_q + PW'(k);
            if (!found && CW'(k) < cnt_q) begin
                if (ent_d[idx].vld) begin
                    found       = 1'b1;
                    head_addr_o = ent_d[idx].addr;
                end else begin
                    lead = lead + 1'b1;
                end
            end
        end
        head_live_o = found;
        npop        = lead + CW'(pop_i && found);
        rd_d        = rd_q + npop[PW-1:0];
        cnt_d       = cnt_q - npop;
        if (push_i) begin
            ent_d[wr_q].vld  = 1'b1;
            ent_d[wr_q].addr = push_addr_i;
            wr_d             = wr_q + 1'b1;
            cnt_d            = cnt_d + 1'b1;
        end
        if (flush_i) begin
            ent_d = '0;
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    // Queue state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ldvio_vld_ctrl.sv
// Write-port scheduler for the load-violation valid-bit RAM: arbitrates clears,
// queued sets and incoming sets in IDLE, and walks every entry to 0 after a flush.
// LDVIO_VLD_CTRL_PERF_EN adds the perf_* counter outputs.
module ldvio_vld_ctrl
    import ldvio_pkg::*;
#(
    parameter int DEPTH      = LDVIO_DEPTH,
    parameter int INDEX      = LDVIO_INDEX,
    parameter int SETQ_DEPTH = LDVIO_SETQ_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    ldvio_vld_ctrl_if.slave       bus
`ifdef LDVIO_VLD_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_setq_stall_o,
    output logic [31:0]           perf_sweep_cyc_o,
    output logic [INDEX:0]        perf_setq_hwm_o
`endif
);

    ldvio_state_e     state_q, state_d;
    logic [INDEX-1:0] ptr_q, ptr_d;
    ldvio_wr_t        wr_q, wr_d;

    logic             set_rdy, clr_rdy, set_acc;
    logic             q_push, q_pop, q_kill, q_flush;
    logic             q_full, q_empty, q_head_live;
    logic [INDEX-1:0] q_head_addr;
`ifdef LDVIO_VLD_CTRL_PERF_EN
    logic [$clog2(SETQ_DEPTH):0] q_cnt;
`endif

    ldvio_setq #(.DEPTH(SETQ_DEPTH)) u_setq (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (q_flush),
        .push_i      (q_push),
        .push_addr_i (bus.set_addr_i),
        .kill_i      (q_kill),
        .kill_addr_i (bus.clr_addr_i),
        .pop_i       (q_pop),
        .head_live_o (q_head_live),
        .head_addr_o (q_head_addr),
        .full_o      (q_full),
        .empty_o     (q_empty)
`ifdef LDVIO_VLD_CTRL_PERF_EN
        ,
        .cnt_o       (q_cnt)
`endif
    );

    assign bus.set_ready_o = set_rdy;
    assign bus.clr_ready_o = clr_rdy;
    assign bus.busy_o      = (state_q == SWEEP);
    assign bus.we_o        = wr_q.we;
    assign bus.waddr_o     = wr_q.addr;
    assign bus.wdata_o     = wr_q.data;

    // FSM next state, readies, single-winner arbitration and sweep writes.
    // A flush cycle itself never writes; the sweep starts on the following cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_d    = '0;
        set_rdy = 1'b0;
        clr_rdy = 1'b0;
        set_acc = 1'b0;
        q_push  = 1'b0;
        q_pop   = 1'b0;
        q_kill  = 1'b0;
        q_flush = 1'b0;
        case (state_q)
            IDLE: begin
                clr_rdy = 1'b1;
                set_rdy = !q_full;
                set_acc = bus.set_valid_i && set_rdy;
                if (bus.flush_i) begin
                    q_flush = 1'b1;
                    state_d = SWEEP;
                    ptr_d   = '0;
                end else if (bus.clr_valid_i) begin
                    // Clear wins; a same-address incoming set is swallowed.
                    q_kill    = 1'b1;
                    wr_d.we   = 1'b1;
                    wr_d.addr = bus.clr_addr_i;
                    wr_d.data = 1'b0;
                    q_push    = set_acc && (bus.set_addr_i != bus.clr_addr_i);
                end else if (!q_empty && q_head_live) begin
                    q_pop     = 1'b1;
                    wr_d.we   = 1'b1;
                    wr_d.addr = q_head_addr;
                    wr_d.data = 1'b1;
                    q_push    = set_acc;
                end else if (set_acc) begin
                    wr_d.we   = 1'b1;
                    wr_d.addr = bus.set_addr_i;
                    wr_d.data = 1'b1;
                end
            end
            SWEEP: begin
                if (bus.flush_i) begin
                    q_flush = 1'b1;
                    ptr_d   = '0;
                end else begin
                    wr_d.we   = 1'b1;
                    wr_d.addr = ptr_q;
                    wr_d.data = 1'b0;
                    if (ptr_q == INDEX'(DEPTH - 1)) begin
                        state_d = IDLE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, sweep pointer and registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
        end
    end

`ifdef LDVIO_VLD_CTRL_PERF_EN
    logic [31:0]   stall_q, stall_d, swc_q, swc_d;
    logic [INDEX:0] hwm_q, hwm_d;

    // Saturating stall/sweep counters and queue occupancy peak.
    always_comb begin
        stall_d = stall_q;
        swc_d   = swc_q;
        hwm_d   = hwm_q;
        if (bus.set_valid_i && !set_rdy && stall_q != '1)
            stall_d = stall_q + 1'b1;
        if (state_q == SWEEP && swc_q != '1)
            swc_d = swc_q + 1'b1;
        if ((INDEX + 1)'(q_cnt) > hwm_q)
            hwm_d = (INDEX + 1)'(q_cnt);
    end

    // Perf counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            swc_q   <= '0;
            hwm_q   <= '0;
        end else begin
            stall_q <= stall_d;
            swc_q   <= swc_d;
            hwm_q   <= hwm_d;
        end
    end

    assign perf_setq_stall_o = stall_q;
    assign perf_sweep_cyc_o  = swc_q;
    assign perf_setq_hwm_o   = hwm_q;
`endif

endmodule
